// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter on the CPU data port. A 16-byte window
//   at BASE_ADDR holds four word registers selected by addr_i[3:2]:
//     0 TXDATA   : write pushes wdata_i[7:0] into the TX FIFO, reads 0
//     1 STATUS   : {level[15:8], irq_en[4], ovf[3], empty[2], full[1], busy[0]}
//                  writes: bit3=1 clears OVF, bit4 sets IRQ_EN
//     2 BAUD_DIV : clocks per bit (16 bits, a write of 0 stores 1)
//     3 reserved : reads 0, writes ignored
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   addr_i      : CPU data address
//   wdata_i     : CPU write data
//   wr_i        : write qualifier, meaningful only with strobe_i
//   strobe_i    : one-cycle data access strobe
//   rdata_o     : registered read data, updated by read hits only
//   hit_o       : high for the cycle after a strobe that hit the window
//   tx_o        : registered serial output, idles high
//   irq_o       : high while FIFO level <= FIFO_DEPTH/2 and IRQ_EN is set
// -----------------------------------------------------------------------------
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter logic [15:0] CLKS_PER_BIT = 16'd868
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic        wr_i,
   input  logic        strobe_i,
   output logic [31:0] rdata_o,
   output logic        hit_o,
   output logic        tx_o,
   output logic        irq_o
);

   localparam int unsigned AW       = $clog2(FIFO_DEPTH);
   localparam logic [1:0]  REG_TX   = 2'd0;
   localparam logic [1:0]  REG_STAT = 2'd1;
   localparam logic [1:0]  REG_BAUD = 2'd2;
   localparam logic [8:0]  HALF     = 9'(FIFO_DEPTH / 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // ---------------------------------------------------------------- decode
   logic       hit;
   logic       wr_hit;
   logic       rd_hit;
   logic [1:0] sel;
   logic       push_req;
   logic       unused_bits;

   assign hit      = strobe_i && (addr_i[31:4] == BASE_ADDR[31:4]);
   assign sel      = addr_i[3:2];
   assign wr_hit   = hit && wr_i;
   assign rd_hit   = hit && !wr_i;
   assign push_req = wr_hit && (sel == REG_TX);

   assign unused_bits = ^{addr_i[1:0], wdata_i[31:16]};

   // ------------------------------------------------------------ registers
   logic [31:0] rdata_q;
   logic        hit_q;
   logic [15:0] baud_div_q;
   logic        irq_en_q;
   logic        ovf_q;

   // ----------------------------------------------------------------- FIFO
   // One extra pointer bit distinguishes full from empty when the
   // index bits match.
   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   logic [AW:0] level;
   logic [8:0]  level9;
   logic        fifo_empty;
   logic        fifo_full;
   logic        push_ok;
   logic        pop;
   logic [7:0]  fifo_rdata;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level      = wr_ptr_q - rd_ptr_q;
   assign level9     = 9'(level);
   assign fifo_rdata = mem_q[rd_ptr_q[AW-1:0]];
   // A full FIFO still takes a byte when the transmitter frees a slot
   // on the same edge.
   assign push_ok    = push_req && (!fifo_full || pop);

   // ---------------------------------------------------------- transmitter
   state_t      state_q,    state_d;
   logic [7:0]  shift_q,    shift_d;
   logic [15:0] bit_div_q,  bit_div_d;
   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]  bit_idx_q,  bit_idx_d;
   logic        tx_q,       tx_d;
   logic        busy;

   // ----------------------------------------------------- read data mux
   logic [31:0] status_word;
   logic [31:0] rd_mux;

   assign status_word = {16'h0000, level9[7:0], 3'b000,
                         irq_en_q, ovf_q, fifo_empty, fifo_full, busy};

   always_comb begin
      rd_mux = '0;
      case (sel)
         REG_STAT: rd_mux = status_word;
         REG_BAUD: rd_mux = {16'h0000, baud_div_q};
         default:  rd_mux = '0;
      endcase
   end

   // ------------------------------------------------- CSR / bus sequential
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q    <= '0;
         hit_q      <= 1'b0;
         baud_div_q <= CLKS_PER_BIT;
         irq_en_q   <= 1'b0;
         ovf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         hit_q <= hit;
         if (rd_hit) begin
            rdata_q <= rd_mux;
         end
         if (wr_hit && (sel == REG_BAUD)) begin
            baud_div_q <= (wdata_i[15:0] == 16'h0000) ? 16'd1 : wdata_i[15:0];
         end
         if (wr_hit && (sel == REG_STAT)) begin
            irq_en_q <= wdata_i[4];
         end
         // A dropped byte outranks a simultaneous W1C.
         if (push_req && !push_ok) begin
            ovf_q <= 1'b1;
         end else if (wr_hit && (sel == REG_STAT) && wdata_i[3]) begin
            ovf_q <= 1'b0;
         end
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // FIFO storage needs no reset: pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i[7:0];
      end
   end

   // --------------------------------------------------- FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         bit_div_q  <= '0;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_div_q  <= bit_div_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         tx_q       <= tx_d;
      end
   end

   // ------------------------------------------------------- FSM next state
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_div_d  = bit_div_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_d    = S_START;
               shift_d    = fifo_rdata;
               bit_div_d  = baud_div_q;
               baud_cnt_d = baud_div_q - 16'd1;
            end
         end
         S_START: begin
            if (baud_cnt_q == 16'd0) begin
               state_d    = S_DATA;
               bit_idx_d  = 3'd0;
               baud_cnt_d = bit_div_q - 16'd1;
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end
         S_DATA: begin
            if (baud_cnt_q == 16'd0) begin
               baud_cnt_d = bit_div_q - 16'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end
         S_STOP: begin
            if (baud_cnt_q == 16'd0) begin
               if (!fifo_empty) begin
                  // Back-to-back frame: reload straight into START.
                  state_d    = S_START;
                  shift_d    = fifo_rdata;
                  bit_div_d  = baud_div_q;
                  baud_cnt_d = baud_div_q - 16'd1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q - 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ----------------------------------------------------------- FSM outputs
   // tx is derived from the next state so the line moves on the same edge
   // as the state change, keeping the output registered without a lag.
   always_comb begin
      pop  = (state_d == S_START) && ((state_q == S_IDLE) || (state_q == S_STOP));
      busy = (state_q != S_IDLE);
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   assign rdata_o = rdata_q;
   assign hit_o   = hit_q;
   assign tx_o    = tx_q;
   assign irq_o   = irq_en_q && (level9 <= HALF);

endmodule
